// File: rtl/pbl_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pbl_pkg
// Shared definitions for the PBL access-control panel: profile switch codes,
// controller state encoding, number of selectable functions and the
// profile-code to one-hot decoder used by the top level.
// ---------------------------------------------------------------------------
package pbl_pkg;

    localparam logic [2:0] PROF_ADM = 3'b101;
    localparam logic [2:0] PROF_TST = 3'b011;
    localparam logic [2:0] PROF_USR = 3'b001;
    localparam logic [2:0] PROF_GST = 3'b110;

    localparam int NUM_FUNCS = 7;

    typedef enum logic [2:0] {
        IDLE,
        SESSION,
        EXEC,
        DENY,
        LOCKED
    } state_t;

    // One-hot profile {GST,USR,TST,ADM}; all zero marks an invalid code.
    function automatic logic [3:0] prof_onehot(input logic [2:0] code);
        logic [3:0] oh;
        oh = 4'b0000;
        case (code)
            PROF_ADM: oh = 4'b0001;
            PROF_TST: oh = 4'b0010;
            PROF_USR: oh = 4'b0100;
            PROF_GST: oh = 4'b1000;
            default:  oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/pbl_access_ctrl_debounce.sv
// ---------------------------------------------------------------------------
// pbl_debounce
// Two-flop synchroniser followed by a stability counter. The debounced level
// follows the synchronised input only after DEB_CYC consecutive samples that
// differ from the current level; shorter glitches are discarded.
// Ports:
//   CLK   system clock
//   RST   asynchronous active-high reset
//   din   raw asynchronous input
//   level debounced level
//   rise  one-cycle pulse when level goes 0 -> 1
// ---------------------------------------------------------------------------
module pbl_debounce #(
    parameter int DEB_CYC = 500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEB_CYC + 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1   <= din;
            r_s2   <= r_s1;
            r_rise <= 1'b0;
            if (r_s2 == r_level) begin
                // Any sample agreeing with the current level restarts the run.
                r_cnt <= '0;
            end else if (r_cnt >= CNT_W'(DEB_CYC - 1)) begin
                r_level <= r_s2;
                r_rise  <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/pbl_access_ctrl.sv
// ---------------------------------------------------------------------------
// pbl_access_ctrl
// Access-control panel controller. A login latches the profile on CH[7:5];
// function requests f = {B3,B2,CH4} are checked against the profile's
// permission mask. Provides session timeout, deny indication and lockout
// after MAX_FAIL consecutive invalid logins.
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   CH[7:0]           switches: [7:5] profile code, [4] function LSB
//   B0 / B1           confirm / logout buttons
//   B3, B2            function code bits [2:1]
//   LED_PROF[3:0]     latched profile one-hot {GST,USR,TST,ADM}
//   LED_SES           session active (SESSION or EXEC)
//   LED_DENY          DENY indication
//   LED_LOCK          LOCKED indication
//   M1_C0             matrix column enable (high in EXEC)
//   M1_L[6:0]         matrix rows, active-low, row f-1 lit in EXEC
// ---------------------------------------------------------------------------
module pbl_access_ctrl
    import pbl_pkg::*;
#(
    parameter int         DEB_CYC     = 500000,
    parameter int         HOLD_CYC    = 25000000,
    parameter int         TIMEOUT_CYC = 500000000,
    parameter int         LOCK_CYC    = 250000000,
    parameter int         MAX_FAIL    = 3,
    parameter logic [6:0] PERM_ADM    = 7'h7F,
    parameter logic [6:0] PERM_TST    = 7'h2F,
    parameter logic [6:0] PERM_USR    = 7'h07,
    parameter logic [6:0] PERM_GST    = 7'h01
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] CH,
    input  logic       B0,
    input  logic       B1,
    input  logic       B2,
    input  logic       B3,
    output logic [3:0] LED_PROF,
    output logic       LED_SES,
    output logic       LED_DENY,
    output logic       LED_LOCK,
    output logic       M1_C0,
    output logic [6:0] M1_L
);

    // One shared timer serves the hold, idle and lock intervals.
    localparam int TMR_MAX0 = (HOLD_CYC > TIMEOUT_CYC) ? HOLD_CYC : TIMEOUT_CYC;
    localparam int TMR_MAX  = (TMR_MAX0 > LOCK_CYC) ? TMR_MAX0 : LOCK_CYC;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int FAIL_W   = $clog2(MAX_FAIL + 1);

    function automatic logic [NUM_FUNCS-1:0] perm_mask(input logic [3:0] oh);
        logic [NUM_FUNCS-1:0] m;
        m = '0;
        if (oh[0]) m = m | PERM_ADM;
        if (oh[1]) m = m | PERM_TST;
        if (oh[2]) m = m | PERM_USR;
        if (oh[3]) m = m | PERM_GST;
        return m;
    endfunction

    function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] t);
        return (t == TMR_W'(TMR_MAX)) ? t : t + TMR_W'(1);
    endfunction

    logic [7:0]        r_ch_s1;
    logic [7:0]        r_ch_s2;
    logic              w_b0_lvl, w_b0_rise;
    logic              w_b1_lvl, w_b1_rise;
    logic              w_b2_lvl, w_b2_rise;
    logic              w_b3_lvl, w_b3_rise;
    logic              w_unused;

    logic [2:0]        w_code;
    logic [3:0]        w_oh;
    logic              w_valid;
    logic [2:0]        w_f;
    logic [NUM_FUNCS:0] w_perm_ext;
    logic              w_perm;
    logic [FAIL_W-1:0] w_fail_nxt;

    state_t            r_state;
    logic [3:0]        r_prof;
    logic [2:0]        r_code;
    logic [2:0]        r_f;
    logic              r_ret;
    logic [FAIL_W-1:0] r_fail;
    logic [TMR_W-1:0]  r_tmr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ch_s1 <= '0;
            r_ch_s2 <= '0;
        end else begin
            r_ch_s1 <= CH;
            r_ch_s2 <= r_ch_s1;
        end
    end

    pbl_debounce #(.DEB_CYC(DEB_CYC)) u_deb_b0 (
        .CLK(CLK), .RST(RST), .din(B0), .level(w_b0_lvl), .rise(w_b0_rise));
    pbl_debounce #(.DEB_CYC(DEB_CYC)) u_deb_b1 (
        .CLK(CLK), .RST(RST), .din(B1), .level(w_b1_lvl), .rise(w_b1_rise));
    pbl_debounce #(.DEB_CYC(DEB_CYC)) u_deb_b2 (
        .CLK(CLK), .RST(RST), .din(B2), .level(w_b2_lvl), .rise(w_b2_rise));
    pbl_debounce #(.DEB_CYC(DEB_CYC)) u_deb_b3 (
        .CLK(CLK), .RST(RST), .din(B3), .level(w_b3_lvl), .rise(w_b3_rise));

    assign w_unused = ^{w_b0_lvl, w_b1_lvl, w_b2_rise, w_b3_rise, r_ch_s2[3:0]};

    assign w_code  = r_ch_s2[7:5];
    assign w_oh    = prof_onehot(w_code);
    assign w_valid = |w_oh;
    assign w_f     = {w_b3_lvl, w_b2_lvl, r_ch_s2[4]};

    // Extra zero bit keeps the f-1 index in range when f = 0.
    assign w_perm_ext = {1'b0, perm_mask(r_prof)};
    assign w_perm     = (w_f != 3'd0) && w_perm_ext[w_f - 3'd1];

    assign w_fail_nxt = (r_fail == FAIL_W'(MAX_FAIL)) ? r_fail : r_fail + FAIL_W'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_prof  <= '0;
            r_code  <= '0;
            r_f     <= '0;
            r_ret   <= 1'b0;
            r_fail  <= '0;
            r_tmr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_b0_rise) begin
                        r_tmr <= '0;
                        if (w_valid) begin
                            r_prof  <= w_oh;
                            r_code  <= w_code;
                            r_fail  <= '0;
                            r_state <= SESSION;
                        end else begin
                            r_fail <= w_fail_nxt;
                            if (w_fail_nxt == FAIL_W'(MAX_FAIL)) begin
                                r_state <= LOCKED;
                            end else begin
                                r_ret   <= 1'b0;
                                r_state <= DENY;
                            end
                        end
                    end
                end
                SESSION: begin
                    if (w_b1_rise) begin
                        r_state <= IDLE;
                        r_prof  <= '0;
                        r_code  <= '0;
                        r_f     <= '0;
                        r_tmr   <= '0;
                    end else if (w_b0_rise) begin
                        r_tmr <= '0;
                        if (w_f == 3'd0) begin
                            r_state <= SESSION;
                        end else if (w_perm) begin
                            r_f     <= w_f;
                            r_state <= EXEC;
                        end else begin
                            r_ret   <= 1'b1;
                            r_state <= DENY;
                        end
                    end else if ((r_tmr >= TMR_W'(TIMEOUT_CYC - 1)) || (w_code != r_code)) begin
                        r_state <= IDLE;
                        r_prof  <= '0;
                        r_code  <= '0;
                        r_f     <= '0;
                        r_tmr   <= '0;
                    end else begin
                        r_tmr <= tmr_inc(r_tmr);
                    end
                end
                EXEC: begin
                    if (w_b1_rise) begin
                        r_state <= IDLE;
                        r_prof  <= '0;
                        r_code  <= '0;
                        r_f     <= '0;
                        r_tmr   <= '0;
                    end else if (r_tmr >= TMR_W'(HOLD_CYC - 1)) begin
                        r_state <= SESSION;
                        r_tmr   <= '0;
                    end else begin
                        r_tmr <= tmr_inc(r_tmr);
                    end
                end
                DENY: begin
                    if (r_ret && w_b1_rise) begin
                        r_state <= IDLE;
                        r_prof  <= '0;
                        r_code  <= '0;
                        r_f     <= '0;
                        r_ret   <= 1'b0;
                        r_tmr   <= '0;
                    end else if (r_tmr >= TMR_W'(HOLD_CYC - 1)) begin
                        r_state <= r_ret ? SESSION : IDLE;
                        r_ret   <= 1'b0;
                        r_tmr   <= '0;
                    end else begin
                        r_tmr <= tmr_inc(r_tmr);
                    end
                end
                LOCKED: begin
                    if (r_tmr >= TMR_W'(LOCK_CYC - 1)) begin
                        r_state <= IDLE;
                        r_fail  <= '0;
                        r_tmr   <= '0;
                    end else begin
                        r_tmr <= tmr_inc(r_tmr);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_prof  <= '0;
                    r_code  <= '0;
                    r_f     <= '0;
                    r_ret   <= 1'b0;
                    r_tmr   <= '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the registered state, one cycle behind it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            LED_PROF <= '0;
            LED_SES  <= 1'b0;
            LED_DENY <= 1'b0;
            LED_LOCK <= 1'b0;
            M1_C0    <= 1'b0;
            M1_L     <= 7'h7F;
        end else begin
            LED_PROF <= r_prof;
            LED_SES  <= (r_state == SESSION) || (r_state == EXEC);
            LED_DENY <= (r_state == DENY);
            LED_LOCK <= (r_state == LOCKED);
            M1_C0    <= (r_state == EXEC);
            M1_L     <= (r_state == EXEC) ? ~(7'd1 << (r_f - 3'd1)) : 7'h7F;
        end
    end

endmodule

// File: doc/pbl_access_ctrl.md
Name: pbl_access_ctrl

Overview:
Sequential successor to the combinational profile/function decoder for the PBL access-control panel. Latches a login profile from switches CH[7:5] and accepts function requests coded on {B3,B2,CH4}. Checks each request against per-profile permission masks and drives the 1-column LED matrix and status LEDs. Adds debounced buttons, session timeout, a deny indication and lockout after repeated invalid logins.

Parameters:
DEB_CYC, 500000, cycles a button must be stable before it is accepted
HOLD_CYC, 25000000, cycles the EXEC and DENY displays are held
TIMEOUT_CYC, 500000000, session idle cycles before automatic logout
LOCK_CYC, 250000000, lockout duration in cycles
MAX_FAIL, 3, consecutive invalid logins that trigger LOCKED (range 1..15)
PERM_ADM, 7'h7F, permission mask for ADM (bit i = function i+1)
PERM_TST, 7'h2F, permission mask for TESTER (functions 1-4 and 6)
PERM_USR, 7'h07, permission mask for USER
PERM_GST, 7'h01, permission mask for GUEST

Ports:
CLK  input  1  system clock
RST  input  1  reset, asynchronous, active-high
CH  input  8  slide switches: [7:5] profile code, [4] function LSB
B0  input  1  confirm button (login or execute), active-high
B1  input  1  logout button, active-high
B3, B2  input  1 each  function code bits [2:1]
LED_PROF  output  4  one-hot latched profile {GST,USR,TST,ADM}, 0 outside a session
LED_SES  output  1  session active (SESSION or EXEC)
LED_DENY  output  1  high during DENY
LED_LOCK  output  1  high during LOCKED
M1_C0  output  1  matrix column enable, active-high
M1_L  output  7  matrix rows, active-low; row f-1 lit in EXEC

Behaviour:
- Reset values: LED_PROF=0, LED_SES=0, LED_DENY=0, LED_LOCK=0, M1_C0=0, M1_L=7'h7F, state=IDLE, fail_cnt=0, all timers=0.
- Input conditioning:
  - CH goes through a 2-flop synchroniser.
  - B0, B1, B2 and B3 each pass through a synchroniser plus debouncer.
  - The debounced level changes only after DEB_CYC consecutive equal samples.
  - B0 and B1 produce a one-cycle rise pulse. A glitch shorter than DEB_CYC produces nothing.
- Profile decode on synchronised CH[7:5]: 101=ADM, 011=TST, 001=USR, 110=GST. Any other code is invalid.
- Function code f = {B3,B2,CH4} debounced/synchronised levels, sampled on the B0 pulse.
- FSM states and transitions:
  - IDLE, on B0 pulse:
    - valid profile: latch it, clear fail_cnt, go to SESSION.
    - invalid profile: increment fail_cnt. If the new value equals MAX_FAIL go to LOCKED, otherwise go to DENY with return=IDLE.
  - SESSION, priority B1 > B0 > timeout > profile change:
    - B1 pulse: go to IDLE.
    - B0 pulse with f=0: ignored, idle timer restarts.
    - B0 pulse with f in 1..7 and permission bit f-1 set in the latched profile's mask: go to EXEC, store f.
    - B0 pulse otherwise: go to DENY with return=SESSION.
    - Every B0 pulse restarts the idle timer.
    - Idle timer reaching TIMEOUT_CYC-1: go to IDLE.
    - Synchronised CH[7:5] differing from the latched code: go to IDLE on the next edge.
  - EXEC: hold for HOLD_CYC cycles, then go to SESSION with the idle timer restarted. B1 pulse goes to IDLE immediately. B0 is ignored.
  - DENY: hold for HOLD_CYC cycles, then go to the stored return state. In SESSION-return, B1 goes to IDLE. B0 is ignored.
  - LOCKED: hold for LOCK_CYC cycles, then go to IDLE with fail_cnt cleared. All buttons are ignored.
- Leaving a session clears the latched profile and stored f.
- Outputs are registered and decoded from the state, so they appear one cycle after the transition edge.
  - In EXEC: M1_C0=1 and M1_L = ~(1<<(f-1)).
  - In all other states: M1_C0=0 and M1_L=7'h7F.
- Counter widths: $clog2(max value + 1). Counters saturate, never wrap.
- Reset asserted in any state forces all reset values immediately.

Decomposition:
- Package pbl_pkg holds:
  - Profile code constants PROF_ADM=3'b101, PROF_TST=3'b011, PROF_USR=3'b001, PROF_GST=3'b110.
  - The state enum {IDLE, SESSION, EXEC, DENY, LOCKED}.
  - The constant NUM_FUNCS=7.
- Sub-module pbl_debounce, parameter DEB_CYC, 2-flop synchroniser plus stability counter. Ports: CLK, RST, din, level, rise. Instantiated four times.

Test Plan:
All scenarios use DEB_CYC=4, HOLD_CYC=8, TIMEOUT_CYC=64, LOCK_CYC=32, MAX_FAIL=3.
1. CH[7:5]=101; a 2-cycle B0 glitch, then B0 held 10 cycles -> glitch ignored; after the pulse LED_SES=1 and LED_PROF=4'b0001.
2. ADM session, B3=B2=CH4=1, B0 press -> M1_C0=1 and M1_L=7'b0111111 for 8 cycles, then M1_L=7'h7F and LED_SES still 1.
3. TST session (CH[7:5]=011), f=5, B0 -> LED_DENY=1 for 8 cycles and return to SESSION; then f=6 -> M1_L=7'b1011111.
4. CH[7:5]=000, three B0 presses -> LED_DENY after the first two, LED_LOCK=1 for 32 cycles after the third; a B0 press during lock is ignored; then IDLE with fail_cnt=0.
5. GST session, no presses for 64 cycles -> IDLE, LED_PROF=0. New USR session, then CH[7:5] changed to 101 -> IDLE one cycle after the synchronised change. B1 and B0 pulses in the same cycle -> IDLE.
6. RST pulsed mid-EXEC -> M1_C0=0, M1_L=7'h7F and all LEDs 0 without waiting for a clock edge.
